// File: rtl/rx_pipe_pkg.sv
// Shared constants, FSM states and FIFO entry layout for the RF envelope path.
// Macro LOG_COMPRESS_EN selects log-style pixel compression instead of linear truncation.
package rx_pipe_pkg;
    localparam int DATA_W = 15;
    localparam int PIX_W  = 8;
    localparam int MAG_W  = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} fsm_t;

    typedef struct packed {
        logic             last;
        logic [7:0]       line;
        logic [PIX_W-1:0] pix;
    } fifo_entry_t;

    function automatic logic [PIX_W-1:0] compress(input logic [MAG_W-1:0] mag);
`ifdef LOG_COMPRESS_EN
        logic [3:0]       p;
        logic [MAG_W-1:0] norm;
        p = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) p = 4'(i);
        end
        // Normalise so the leading one sits at the MSB; the next 4 bits are the mantissa.
        norm = mag << (4'(MAG_W - 1) - p);
        return (mag == '0) ? '0 : {p, norm[MAG_W-2 -: 4]};
`else
        return mag[MAG_W-1 -: PIX_W];
`endif
    endfunction
endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO with occupancy and free-slot counts; clr_i empties it in one cycle.
// Write while full is accepted only together with a pop.
module pix_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     wr_vld_i,
    input  logic [W-1:0]             wr_dat_i,
    input  logic                     rd_rdy_i,
    output logic [W-1:0]             rd_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   free_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_wr, do_rd;

    assign do_rd = rd_rdy_i && (count_q != '0);
    assign do_wr = wr_vld_i && ((count_q != FULL_CNT) || do_rd);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr && !clr_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign free_o   = FULL_CNT - count_q;
endmodule

// File: rtl/rf_envelope_decim.sv
// Magnitude detect, peak-hold decimation and pixel compression of DAS samples into a tagged pixel FIFO.
// Sample-to-FIFO latency 2 cycles; non-last pixels dropped (Ovf) unless 2 slots free, Last always reserved.
module rf_envelope_decim
    import rx_pipe_pkg::*;
#(
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_PIX    = 1024
) (
    input  logic                     AD_CLK,
    input  logic                     Rst_n,
    input  logic                     Pr_Gate,
    input  logic                     So_Gate,
    input  logic signed [DATA_W-1:0] DAS_Value,
    input  logic [7:0]               Line_Num,
    output logic [PIX_W-1:0]         Pix_Data,
    output logic [7:0]               Pix_Line,
    output logic                     Pix_Last,
    output logic                     Pix_Valid,
    input  logic                     Pix_Ready,
    output logic                     Ovf
);
    localparam int CNT_W  = $clog2(DECIM);
    localparam int PCNT_W = $clog2(MAX_PIX + 1);
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

    fsm_t              state_q, state_d;
    logic              so_prev_q;
    logic [7:0]        line_q, line_d;
    logic [MAG_W-1:0]  peak_q, peak_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PCNT_W-1:0] pixcnt_q, pixcnt_d;
    logic              push_vld_q, push_vld_d;
    fifo_entry_t       push_dat_q, push_dat_d;
    logic              ovf_q;

    logic [DATA_W-1:0] neg_val;
    logic [MAG_W-1:0]  mag, win_peak;
    logic              take_new, room, wr_vld, drop;
    logic [FCW-1:0]    fifo_cnt, fifo_free;
    fifo_entry_t       head;

    // Only -2^(DATA_W-1) still has its sign bit set after negation.
    assign neg_val = -DAS_Value;
    always_comb begin
        mag = DAS_Value[MAG_W-1:0];
        if (DAS_Value[DATA_W-1]) mag = neg_val[DATA_W-1] ? '1 : neg_val[MAG_W-1:0];
    end

    assign win_peak = (mag > peak_q) ? mag : peak_q;
    assign take_new = So_Gate && ((state_q == IDLE && !so_prev_q) || state_q == FLUSH);

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        peak_d     = peak_q;
        cnt_d      = cnt_q;
        pixcnt_d   = pixcnt_q;
        push_vld_d = 1'b0;
        push_dat_d = push_dat_q;
        case (state_q)
            IDLE, FLUSH: begin
                state_d = IDLE;
                if (take_new) begin
                    state_d  = ACTIVE;
                    line_d   = Line_Num;
                    peak_d   = mag;
                    cnt_d    = CNT_W'(1);
                    pixcnt_d = '0;
                end
            end
            ACTIVE: begin
                if (So_Gate) begin
                    if (cnt_q == CNT_W'(DECIM - 1)) begin
                        peak_d = '0;
                        cnt_d  = '0;
                        if (pixcnt_q < PCNT_W'(MAX_PIX)) begin
                            push_vld_d = 1'b1;
                            push_dat_d = '{last: 1'b0, line: line_q, pix: compress(win_peak)};
                            pixcnt_d   = pixcnt_q + PCNT_W'(1);
                        end
                    end else begin
                        peak_d = win_peak;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Last pixel captured on the fall edge so it sees the same latency as data pixels.
                    state_d    = FLUSH;
                    push_vld_d = 1'b1;
                    push_dat_d = '{last: 1'b1, line: line_q, pix: compress(peak_q)};
                    peak_d     = '0;
                    cnt_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign room   = fifo_free >= FCW'(2);
    assign wr_vld = push_vld_q && !Pr_Gate && (push_dat_q.last || room);
    assign drop   = push_vld_q && !push_dat_q.last && !room;

    always_ff @(posedge AD_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            so_prev_q  <= 1'b0;
            line_q     <= '0;
            peak_q     <= '0;
            cnt_q      <= '0;
            pixcnt_q   <= '0;
            push_vld_q <= 1'b0;
            push_dat_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            so_prev_q <= So_Gate;
            if (Pr_Gate) begin
                state_q    <= IDLE;
                peak_q     <= '0;
                cnt_q      <= '0;
                pixcnt_q   <= '0;
                push_vld_q <= 1'b0;
                ovf_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                line_q     <= line_d;
                peak_q     <= peak_d;
                cnt_q      <= cnt_d;
                pixcnt_q   <= pixcnt_d;
                push_vld_q <= push_vld_d;
                push_dat_q <= push_dat_d;
                ovf_q      <= ovf_q | drop;
            end
        end
    end

    pix_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (AD_CLK),
        .rst_n_i  (Rst_n),
        .clr_i    (Pr_Gate),
        .wr_vld_i (wr_vld),
        .wr_dat_i (push_dat_q),
        .rd_rdy_i (Pix_Ready),
        .rd_dat_o (head),
        .count_o  (fifo_cnt),
        .free_o   (fifo_free)
    );

    assign Pix_Valid = (fifo_cnt != '0);
    assign Pix_Data  = Pix_Valid ? head.pix  : '0;
    assign Pix_Line  = Pix_Valid ? head.line : '0;
    assign Pix_Last  = Pix_Valid ? head.last : 1'b0;
    assign Ovf       = ovf_q;
endmodule
